// File: rtl/fan_speed_ctrl.sv
// rtl/fan_speed_ctrl.sv - fan speed selector driver: button debounce, 5-state speed FSM, PWM streams
//
// Purpose : debounces the speed button, steps OFF->S1..S4->OFF per accepted press,
//           and generates four free-running PWM streams (25/50/75/100 % duty).
// Ports   : i_clk, i_reset (async, active-high), i_btn (raw), i_stop (sync force-off),
//           o_sel[2:0] speed code, o_pwm[3:0] PWM streams, o_press accepted-press pulse,
//           i_timer_btn / o_timer_set[1:0] auto-off timer (only with FAN_TIMER_EN).
// Option  : FAN_TIMER_EN adds the auto-off timer button and countdown.

module fan_btn_deb #(
   parameter int DEB_CYCLES = 10000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_raw,
   output logic o_press
);
   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync1, sync2, deb, deb_d;
   logic [CW-1:0] cnt;

   // Counter runs only while the synchronised level disagrees with the
   // accepted level; any agreement (bounce back) restarts the window.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         deb     <= 1'b0;
         deb_d   <= 1'b0;
         cnt     <= '0;
         o_press <= 1'b0;
      end else begin
         sync1   <= i_raw;
         sync2   <= sync1;
         deb_d   <= deb;
         o_press <= deb & ~deb_d;
         if (sync2 == deb) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            deb <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module fan_speed_ctrl #(
   parameter int PRESC      = 1000,
   parameter int PWM_PERIOD = 100,
   parameter int DEB_CYCLES = 10000,
   parameter int TIMER_UNIT = 1000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_btn,
   input  logic       i_stop,
   output logic [2:0] o_sel,
   output logic [3:0] o_pwm,
   output logic       o_press
`ifdef FAN_TIMER_EN
   ,
   input  logic       i_timer_btn,
   output logic [1:0] o_timer_set
`endif
);
   localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
   // Wide enough to hold PWM_PERIOD itself so D_3 compares correctly.
   localparam int WW = $clog2(PWM_PERIOD + 1);
   localparam int D0 = (1 * PWM_PERIOD) / 4;
   localparam int D1 = (2 * PWM_PERIOD) / 4;
   localparam int D2 = (3 * PWM_PERIOD) / 4;
   localparam int D3 = (4 * PWM_PERIOD) / 4;

   localparam logic [2:0] ST_OFF = 3'd0;
   localparam logic [2:0] ST_S1  = 3'd1;
   localparam logic [2:0] ST_S2  = 3'd2;
   localparam logic [2:0] ST_S3  = 3'd3;
   localparam logic [2:0] ST_S4  = 3'd4;

   logic [PW-1:0] pcnt;
   logic [WW-1:0] wcnt;
   logic          tick, wrap;
   logic [2:0]    state, state_next;
   logic          timer_expire;

   assign tick = (pcnt == PW'(PRESC - 1));
   assign wrap = tick && (wcnt == WW'(PWM_PERIOD - 1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pcnt  <= '0;
         wcnt  <= '0;
         o_pwm <= 4'b0000;
      end else begin
         pcnt <= tick ? '0 : pcnt + 1'b1;
         if (tick) wcnt <= wrap ? '0 : wcnt + 1'b1;
         o_pwm <= {wcnt < WW'(D3), wcnt < WW'(D2), wcnt < WW'(D1), wcnt < WW'(D0)};
      end
   end

   fan_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_speed_deb (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_raw   (i_btn),
      .o_press (o_press)
   );

`ifdef FAN_TIMER_EN
   localparam int TW = $clog2(3 * TIMER_UNIT + 1);

   logic          timer_press;
   logic [1:0]    tset, tset_inc;
   logic [TW-1:0] tcnt;
   logic          counting;

   fan_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_timer_deb (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_raw   (i_timer_btn),
      .o_press (timer_press)
   );

   assign tset_inc     = tset + 2'd1;
   assign counting     = (state != ST_OFF) && (tset != 2'd0);
   assign timer_expire = wrap && counting && (tcnt <= TW'(1));
   assign o_timer_set  = tset;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         tset <= 2'd0;
         tcnt <= '0;
      end else if ((state_next == ST_OFF) && (state != ST_OFF)) begin
         tset <= 2'd0;
         tcnt <= '0;
      end else if (timer_press) begin
         tset <= tset_inc;
         tcnt <= TW'(tset_inc) * TW'(TIMER_UNIT);
      end else if (wrap && counting) begin
         tcnt <= tcnt - 1'b1;
      end
   end
`else
   assign timer_expire = 1'b0;
`endif

   always_comb begin
      state_next = state;
      case (state)
         ST_OFF:  if (o_press) state_next = ST_S1;
         ST_S1:   if (o_press) state_next = ST_S2;
         ST_S2:   if (o_press) state_next = ST_S3;
         ST_S3:   if (o_press) state_next = ST_S4;
         ST_S4:   if (o_press) state_next = ST_OFF;
         default: state_next = ST_OFF;
      endcase
      // Force-off and auto-off both override any simultaneous press.
      if (i_stop || timer_expire) state_next = ST_OFF;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= ST_OFF;
      else         state <= state_next;
   end

   assign o_sel = state;
endmodule

// File: tb/tb_fan_speed_ctrl.sv
// tb/tb_fan_speed_ctrl.sv - directed self-checking bench for fan_speed_ctrl
module tb_fan_speed_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       btn = 1'b0;
   logic       stop = 1'b0;
   logic [2:0] sel;
   logic [3:0] pwm;
   logic       press;
`ifdef FAN_TIMER_EN
   logic       tbtn = 1'b0;
   logic [1:0] tset;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fan_speed_ctrl #(.PRESC(2), .PWM_PERIOD(8), .DEB_CYCLES(4), .TIMER_UNIT(2)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_btn   (btn),
      .i_stop  (stop),
      .o_sel   (sel),
      .o_pwm   (pwm),
      .o_press (press)
`ifdef FAN_TIMER_EN
      ,
      .i_timer_btn (tbtn),
      .o_timer_set (tset)
`endif
   );

   // Stimulus only: full press/release cycle with settle time.
   task automatic press_full();
      btn = 1'b1;
      repeat (10) @(negedge clk);
      btn = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (sel !== 3'd0 || pwm !== 4'b0000 || press !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: sel=%0d pwm=%b press=%b, want 0 0000 0", sel, pwm, press);
      end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (pwm !== 4'b1111) begin
         fails++;
         $display("FAIL pwm_first_clk: pwm=%b, want 1111", pwm);
      end
   endtask

   task automatic test_pwm();
      int ones[4];
      int rises0;
      logic prev0;
      int want[4];
      want = '{16, 32, 48, 64};
      for (int k = 0; k < 4; k++) ones[k] = 0;
      rises0 = 0;
      prev0 = pwm[0];
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) if (pwm[k] === 1'b1) ones[k]++;
         if (pwm[0] === 1'b1 && prev0 === 1'b0) rises0++;
         prev0 = pwm[0];
      end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (ones[k] != want[k]) begin
            fails++;
            $display("FAIL pwm_duty_%0d: high %0d of 64 clk, want %0d", k, ones[k], want[k]);
         end
      end
      tests++;
      if (rises0 != 4) begin
         fails++;
         $display("FAIL pwm_period: %0d rises of pwm0 in 64 clk, want 4", rises0);
      end
      tests++;
      if (sel !== 3'd0) begin
         fails++;
         $display("FAIL idle_sel: sel=%0d, want 0", sel);
      end
   endtask

   task automatic test_five_presses();
      logic [2:0] exp_sel [5];
      int extra;
      exp_sel = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      for (int i = 0; i < 5; i++) begin
         btn = 1'b1;
         repeat (7) @(negedge clk);
         tests++;
         if (press !== 1'b1) begin
            fails++;
            $display("FAIL press_%0d_at7: press=%b, want 1", i, press);
         end
         @(negedge clk);
         tests++;
         if (press !== 1'b0 || sel !== exp_sel[i]) begin
            fails++;
            $display("FAIL sel_%0d_at8: press=%b sel=%0d, want 0 %0d", i, press, sel, exp_sel[i]);
         end
         repeat (2) @(negedge clk);
         btn = 1'b0;
         extra = 0;
         for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (press === 1'b1) extra++;
         end
         tests++;
         if (extra != 0 || sel !== exp_sel[i]) begin
            fails++;
            $display("FAIL release_%0d: pulses=%0d sel=%0d, want 0 %0d", i, extra, sel, exp_sel[i]);
         end
      end
   endtask

   task automatic test_bounce();
      int pulses;
      pulses = 0;
      for (int n = 0; n < 20; n++) begin
         btn = ((n / 2) % 2 == 0);
         @(negedge clk);
         if (press === 1'b1) pulses++;
      end
      btn = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         if (press === 1'b1) begin
            pulses++;
            tests++;
            if (n != 7) begin
               fails++;
               $display("FAIL bounce_latency: pulse at %0d clk, want 7", n);
            end
         end
      end
      tests++;
      if (pulses != 1 || sel !== 3'd1) begin
         fails++;
         $display("FAIL bounce_count: pulses=%0d sel=%0d, want 1 1", pulses, sel);
      end
      btn = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_stop();
      press_full();
      press_full();
      tests++;
      if (sel !== 3'd3) begin
         fails++;
         $display("FAIL stop_setup: sel=%0d, want 3", sel);
      end
      btn = 1'b1;
      repeat (7) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      tests++;
      if (sel !== 3'd0) begin
         fails++;
         $display("FAIL stop_wins: sel=%0d, want 0", sel);
      end
      btn = 1'b0;
      repeat (10) @(negedge clk);
      press_full();
      tests++;
      if (sel !== 3'd0) begin
         fails++;
         $display("FAIL stop_held: sel=%0d, want 0", sel);
      end
      stop = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int pulses;
      press_full();
      press_full();
      tests++;
      if (sel !== 3'd2) begin
         fails++;
         $display("FAIL rst_setup: sel=%0d, want 2", sel);
      end
      btn = 1'b1;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      tests++;
      if (sel !== 3'd0 || pwm !== 4'b0000) begin
         fails++;
         $display("FAIL rst_async: sel=%0d pwm=%b, want 0 0000", sel, pwm);
      end
      btn = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (press === 1'b1) pulses++;
      end
      tests++;
      if (pulses != 0 || sel !== 3'd0) begin
         fails++;
         $display("FAIL rst_no_press: pulses=%0d sel=%0d, want 0 0", pulses, sel);
      end
   endtask

`ifdef FAN_TIMER_EN
   task automatic test_timer();
      int waited;
      do_reset();
      press_full();
      tbtn = 1'b1;
      repeat (8) @(negedge clk);
      tests++;
      if (tset !== 2'd1 || sel !== 3'd1) begin
         fails++;
         $display("FAIL timer_set: tset=%0d sel=%0d, want 1 1", tset, sel);
      end
      tbtn = 1'b0;
      waited = 0;
      while (sel !== 3'd0 && waited < 80) begin
         @(negedge clk);
         waited++;
      end
      tests++;
      if (sel !== 3'd0 || tset !== 2'd0 || waited < 8 || waited > 40) begin
         fails++;
         $display("FAIL timer_expire: sel=%0d tset=%0d after %0d clk, want 0 0 within 8..40", sel, tset, waited);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_pwm();
      test_five_presses();
      test_bounce();
      test_stop();
      test_reset_mid();
`ifdef FAN_TIMER_EN
      test_timer();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
